// File: rtl/cache_refill_arbiter.sv
// Shares one serial memory controller between I-cache refills and D-cache refill/write-back.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed D-over-I priority.
module cache_refill_arbiter #(
  parameter int LINE_BITS = 128
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iI_REQ,
  input  logic [31:0]          iI_ADDR,
  output logic                 oI_GNT,
  output logic                 oI_DONE,
  output logic [LINE_BITS-1:0] oI_LINE,
  input  logic                 iD_REQ,
  input  logic                 iD_WE,
  input  logic [31:0]          iD_ADDR,
  input  logic [LINE_BITS-1:0] iD_WLINE,
  output logic                 oD_GNT,
  output logic                 oD_DONE,
  output logic [LINE_BITS-1:0] oD_RLINE,
  output logic [LINE_BITS-1:0] oCTRL_DATA,
  output logic                 oCTRL_START,
  input  logic [LINE_BITS-1:0] iCTRL_DATA,
  input  logic                 iCTRL_END,
  output logic                 oBUSY
);

  localparam int OFF_BITS = $clog2(LINE_BITS / 8);

  typedef enum logic [2:0] {IDLE, HDR, HDR_W, DAT, DAT_W, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;   // 1 = D-cache owns the transaction
  logic                  we_q, we_d;
  logic [23:0]           addr_q, addr_d;
  logic [LINE_BITS-1:0]  wline_q, wline_d;
  logic [LINE_BITS-1:0]  i_line_q, i_line_d;
  logic [LINE_BITS-1:0]  d_line_q, d_line_d;
  logic [LINE_BITS-1:0]  ctrl_data_q, ctrl_data_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  i_gnt_q, i_gnt_d;
  logic                  d_gnt_q, d_gnt_d;
  logic                  i_done_q, i_done_d;
  logic                  d_done_q, d_done_d;
  logic                  pick_dc;
  logic [LINE_BITS-1:0]  hdr;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{iI_ADDR[31:24], iD_ADDR[31:24]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;   // 1 = D-cache was served most recently

  always_comb begin
    pick_dc = iD_REQ & (~iI_REQ | ~last_q);
    last_d  = last_q;
    if (state_q == IDLE && (iI_REQ || iD_REQ)) begin
      last_d = pick_dc;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    pick_dc = iD_REQ;
  end
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wline_d  = wline_q;
    i_line_d = i_line_q;
    d_line_d = d_line_q;

    case (state_q)
      IDLE: begin
        if (iI_REQ || iD_REQ) begin
          state_d = HDR;
          owner_d = pick_dc;
          we_d    = pick_dc & iD_WE;
          addr_d  = pick_dc ? iD_ADDR[23:0] : iI_ADDR[23:0];
          addr_d[OFF_BITS-1:0] = '0;
          wline_d = iD_WLINE;
        end
      end
      HDR:   state_d = HDR_W;
      HDR_W: if (iCTRL_END) state_d = DAT;
      DAT:   state_d = DAT_W;
      DAT_W: begin
        if (iCTRL_END) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) d_line_d = iCTRL_DATA;
            else         i_line_d = iCTRL_DATA;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    hdr = '0;
    hdr[LINE_BITS-1 -: 8]  = we_d ? 8'h02 : 8'h03;
    hdr[LINE_BITS-9 -: 24] = addr_d;

    ctrl_data_d = '0;
    if (state_d == HDR)             ctrl_data_d = hdr;
    else if (state_d == DAT && we_d) ctrl_data_d = wline_d;

    start_d  = (state_d == HDR) || (state_d == DAT);
    busy_d   = (state_d != IDLE);
    i_gnt_d  = busy_d & ~owner_d;
    d_gnt_d  = busy_d & owner_d;
    i_done_d = (state_d == RESP) & ~owner_d;
    d_done_d = (state_d == RESP) & owner_d;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wline_q     <= '0;
      i_line_q    <= '0;
      d_line_q    <= '0;
      ctrl_data_q <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wline_q     <= wline_d;
      i_line_q    <= i_line_d;
      d_line_q    <= d_line_d;
      ctrl_data_q <= ctrl_data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
    end
  end

  assign oI_GNT      = i_gnt_q;
  assign oI_DONE     = i_done_q;
  assign oI_LINE     = i_line_q;
  assign oD_GNT      = d_gnt_q;
  assign oD_DONE     = d_done_q;
  assign oD_RLINE    = d_line_q;
  assign oCTRL_DATA  = ctrl_data_q;
  assign oCTRL_START = start_q;
  assign oBUSY       = busy_q;

endmodule
